// File: rtl/game_tick_gen.sv
// game_tick_gen: multi-channel programmable tick generator.
// Each channel divides clk by a runtime-loadable divisor. It drives a one-cycle
// tick strobe and a clk_out square wave that toggles on every tick.
// Optional feature macro: GAME_TICK_ONESHOT_EN adds the oneshot/done ports.
// When this macro is defined, a channel halts after the tick it issues while
// its oneshot bit is high. The channel leaves HALT only on a load or a reset.
module game_tick_gen #(
    parameter int          CH          = 4,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 32'd50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    en,
    input  logic [CH-1:0]    load,
    input  logic [CNT_W-1:0] div_in,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    clk_out
`ifdef GAME_TICK_ONESHOT_EN
    ,
    input  logic [CH-1:0]    oneshot,
    output logic [CH-1:0]    done
`endif
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    // Last count value before the wrap. A divisor of 0 or 1 behaves as 1,
    // so that channel ticks on every enabled cycle.
    function automatic logic [CNT_W-1:0] term_limit(input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] lim;
        if (d < CNT_W'(2)) begin
            lim = {CNT_W{1'b0}};
        end else begin
            lim = d - CNT_W'(1);
        end
        return lim;
    endfunction

    logic [CNT_W-1:0] div_q   [CH];
    logic [CNT_W-1:0] div_d   [CH];
    logic [CNT_W-1:0] cnt_q   [CH];
    logic [CNT_W-1:0] cnt_d   [CH];
    logic [0:0]       state_q [CH];
    logic [0:0]       state_d [CH];
    logic [CH-1:0]    tick_q;
    logic [CH-1:0]    tick_d;
    logic [CH-1:0]    clk_out_q;
    logic [CH-1:0]    clk_out_d;
    logic [CH-1:0]    oneshot_s;

`ifdef GAME_TICK_ONESHOT_EN
    logic [CH-1:0]    done_q;
    logic [CH-1:0]    done_d;

    assign oneshot_s = oneshot;
    assign done      = done_q;
`else
    // In a free-running build, no channel ever requests a halt.
    assign oneshot_s = {CH{1'b0}};
`endif

    assign tick    = tick_q;
    assign clk_out = clk_out_q;

    // Per-channel next-state logic. A load takes priority over a pause,
    // and a pause takes priority over the normal run/halt count.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            div_d[i]     = div_q[i];
            cnt_d[i]     = cnt_q[i];
            state_d[i]   = state_q[i];
            tick_d[i]    = 1'b0;
            clk_out_d[i] = clk_out_q[i];
            if (load[i]) begin
                div_d[i]   = div_in;
                cnt_d[i]   = {CNT_W{1'b0}};
                state_d[i] = ST_RUN;
            end else if (!en[i]) begin
                // Paused: everything holds and no tick is issued.
                tick_d[i] = 1'b0;
            end else if (state_q[i] == ST_RUN) begin
                // The >= comparison keeps a shrunken divisor from causing a wrap.
                if (cnt_q[i] >= term_limit(div_q[i])) begin
                    cnt_d[i]     = {CNT_W{1'b0}};
                    tick_d[i]    = 1'b1;
                    clk_out_d[i] = ~clk_out_q[i];
                    if (oneshot_s[i]) begin
                        state_d[i] = ST_HALT;
                    end else begin
                        state_d[i] = ST_RUN;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                // Halted: the count holds until the next load.
                cnt_d[i] = cnt_q[i];
            end
        end
    end

`ifdef GAME_TICK_ONESHOT_EN
    // The done output mirrors the HALT state it is about to enter.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            if (state_d[i] == ST_HALT) begin
                done_d[i] = 1'b1;
            end else begin
                done_d[i] = 1'b0;
            end
        end
    end

    // Register the done flag, with a synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= {CH{1'b0}};
        end else begin
            done_q <= done_d;
        end
    end
`endif

    // Channel state registers, with a synchronous reset that overrides any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                div_q[i]   <= RST_DIV;
                cnt_q[i]   <= {CNT_W{1'b0}};
                state_q[i] <= ST_RUN;
            end
            tick_q    <= {CH{1'b0}};
            clk_out_q <= {CH{1'b0}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                div_q[i]   <= div_d[i];
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

endmodule
